// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter.
// State encodings are exported as plain logic constants for the FSM register.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_DROP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_REQ  = ARB_REQ;
  localparam logic [1:0] ST_WAIT = ARB_WAIT;
  localparam logic [1:0] ST_DROP = ARB_DROP;

  localparam int PERF_W = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data, memory-port and perf signals around the arbiter.
// The arbiter uses the slave view; the pipeline/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic [31:0]       perf_if_wait;
  logic [31:0]       perf_d_wait;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  m_gnt, m_rvalid, m_rdata,
    output if_rdata, if_valid, if_stall,
    output d_rdata, d_valid, d_stall,
    output m_req, m_we, m_addr, m_wdata, m_be,
    output perf_if_wait, perf_d_wait
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output m_gnt, m_rvalid, m_rdata,
    input  if_rdata, if_valid, if_stall,
    input  d_rdata, d_valid, d_stall,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    input  perf_if_wait, perf_d_wait
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches and data accesses onto one
// memory port with data priority, one transaction outstanding, flushable fetches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [PERF_W-1:0] perf_if_q, perf_if_d;
  logic [PERF_W-1:0] perf_d_q, perf_d_d;

  logic if_stall, d_stall;
  logic d_elig, if_elig, flush_hit;

  assign if_stall  = bus.if_req & ~if_valid_q;
  assign d_stall   = bus.d_req & ~d_valid_q;
  // A requester is blocked in its own valid cycle so a held request is not reissued.
  assign d_elig    = bus.d_req & ~d_valid_q;
  assign if_elig   = bus.if_req & ~bus.if_flush & ~if_valid_q;
  assign flush_hit = bus.if_flush & (owner_q == OWN_IF);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    perf_if_d  = perf_if_q + PERF_W'(if_stall);
    perf_d_d   = perf_d_q + PERF_W'(d_stall);

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (d_elig) begin
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_be_d    = bus.d_be;
          state_d   = ST_REQ;
        end else if (if_elig) begin
          owner_d   = OWN_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = bus.if_addr;
          m_wdata_d = '0;
          m_be_d    = '1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush_hit) begin
          drop_d = 1'b1;
        end
        if (bus.m_gnt) begin
          m_req_d = 1'b0;
          state_d = (drop_q | flush_hit) ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flush that coincides with the response still discards the fetch.
        if (flush_hit) begin
          state_d = bus.m_rvalid ? ST_IDLE : ST_DROP;
          drop_d  = ~bus.m_rvalid;
        end else if (bus.m_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.m_rdata;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = bus.m_rdata;
          end
        end
      end
      ST_DROP: begin
        if (bus.m_rvalid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      drop_q     <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      perf_if_q  <= '0;
      perf_d_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      perf_if_q  <= perf_if_d;
      perf_d_q   <= perf_d_d;
    end
  end

  assign bus.m_req        = m_req_q;
  assign bus.m_we         = m_we_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_wdata      = m_wdata_q;
  assign bus.m_be         = m_be_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.if_stall     = if_stall;
  assign bus.d_valid      = d_valid_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_stall      = d_stall;
  assign bus.perf_if_wait = perf_if_q;
  assign bus.perf_d_wait  = perf_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stage drivers push expected responses,
// a monitor pops them on if_valid/d_valid, a memory responder plays the port.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          req_cyc;
  } txn_t;

  typedef struct {
    bit          we;
    logic [31:0] data;
  } d_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int gnt_min = 0, gnt_max = 0, rv_min = 1, rv_max = 1;
  int last_dv_cyc = 0;

  logic [31:0] if_q[$];
  d_exp_t      d_q[$];
  txn_t        log_q[$];
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Instruction ROM below 0x1000; data region above with a known power-up pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] dinit(input logic [31:0] a);
    return a ^ 32'hA5A50000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: random or fixed gnt/rvalid delays, one response per grant.
  initial begin : responder
    bit   req_seen;
    bit   rsp_pend;
    int   gnt_left;
    int   rsp_left;
    logic [31:0] rsp_data;
    logic [31:0] cur;
    txn_t held;
    req_seen = 0; rsp_pend = 0; gnt_left = 0; rsp_left = 0; rsp_data = '0;
    held = '{addr: '0, we: 1'b0, wdata: '0, be: '0, req_cyc: 0};
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_gnt    = 1'b0;
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = $urandom;
      if (!rst_n) begin
        req_seen = 0;
        rsp_pend = 0;
      end else if (rsp_pend) begin
        checkOutput("one_outstanding", bus.m_req, 0);
        if (rsp_left == 0) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = rsp_data;
          rsp_pend     = 0;
        end else begin
          rsp_left--;
        end
      end else if (bus.m_req) begin
        if (!req_seen) begin
          req_seen = 1;
          gnt_left = $urandom_range(gnt_max, gnt_min);
          held = '{addr: bus.m_addr, we: bus.m_we, wdata: bus.m_wdata, be: bus.m_be, req_cyc: cyc};
        end else begin
          checkOutput("m_hold_ctl", {bus.m_we, bus.m_be, bus.m_addr}, {held.we, held.be, held.addr});
          checkOutput("m_hold_wdata", bus.m_wdata, held.wdata);
        end
        if (gnt_left == 0) begin
          bus.m_gnt = 1'b1;
          req_seen  = 0;
          log_q.push_back(held);
          cur = env_mem.exists(held.addr) ? env_mem[held.addr] : dinit(held.addr);
          if (held.we) begin
            env_mem[held.addr] = merge(cur, held.wdata, held.be);
            rsp_data = $urandom;
          end else begin
            rsp_data = (held.addr < 32'h1000) ? rom(held.addr) : cur;
          end
          rsp_pend = 1;
          rsp_left = $urandom_range(rv_max, rv_min) - 1;
        end else begin
          gnt_left--;
        end
      end
    end
  end

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  initial begin : monitor
    d_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_valid) begin
        checkOutput("if_valid_expected", if_q.size() != 0, 1);
        if (if_q.size() != 0) checkOutput("if_rdata", bus.if_rdata, if_q.pop_front());
      end
      if (bus.d_valid) begin
        last_dv_cyc = cyc;
        checkOutput("d_valid_expected", d_q.size() != 0, 1);
        if (d_q.size() != 0) begin
          e = d_q.pop_front();
          if (!e.we) checkOutput("d_rdata", bus.d_rdata, e.data);
        end
      end
    end
  end

  // Fetch from addr; optionally flush flush_at cycles after issue if not yet completed.
  task automatic apply_fetch(input logic [31:0] addr, input int flush_at, output int lat);
    int c;
    bit done;
    c = 0; done = 0; lat = -1;
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    if_q.push_back(rom(addr));
    while (!done) begin
      if (c >= 1 && bus.if_valid) begin
        lat = c;
        done = 1;
        bus.if_req = 1'b0;
      end else if (c == flush_at) begin
        bus.if_flush = 1'b1;
        if_q.delete(if_q.size() - 1);
        @(negedge clk);
        bus.if_flush = 1'b0;
        bus.if_req   = 1'b0;
        done = 1;
      end else if (c > 300) begin
        n_vec++; n_err++;
        $display("[TB] FAIL fetch_timeout: got no if_valid for 0x%0h, expected one", addr);
        if_q.delete(if_q.size() - 1);
        bus.if_req = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic apply_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output int lat);
    int c;
    logic [31:0] cur;
    c = 0; lat = -1;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
    cur = ref_mem.exists(addr) ? ref_mem[addr] : dinit(addr);
    if (we) begin
      ref_mem[addr] = merge(cur, wdata, be);
      d_q.push_back('{we: 1'b1, data: '0});
    end else begin
      d_q.push_back('{we: 1'b0, data: cur});
    end
    while (lat < 0) begin
      @(negedge clk);
      c++;
      if (bus.d_valid) lat = c;
      else if (c > 300) begin
        n_vec++; n_err++;
        $display("[TB] FAIL data_timeout: got no d_valid for 0x%0h, expected one", addr);
        d_q.delete(d_q.size() - 1);
        lat = 0;
      end
    end
    bus.d_req = 1'b0;
  endtask

  task automatic set_delays(input int gmin, input int gmax, input int rmin, input int rmax);
    gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
  endtask

  task automatic applyStimulus(input int n_ops);
    fork
      begin
        int lat;
        for (int i = 0; i < n_ops; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          apply_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1, lat);
        end
      end
      begin
        int lat;
        for (int i = 0; i < n_ops; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          apply_data(1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)),
                     $urandom, 4'($urandom_range(1, 15)), lat);
        end
      end
    join
  endtask

  initial begin : main
    int lat;
    int lat_d;
    int i0;
    logic [31:0] p_if, p_d;
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    #3;
    checkOutput("rst_m_ctl", {bus.m_req, bus.m_we, bus.m_be, bus.m_addr}, 0);
    checkOutput("rst_m_wdata", bus.m_wdata, 0);
    checkOutput("rst_valids", {bus.if_valid, bus.d_valid}, 0);
    checkOutput("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    checkOutput("rst_perf", {bus.perf_if_wait, bus.perf_d_wait}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single fetch, minimum latency");
    set_delays(0, 0, 1, 1);
    p_if = bus.perf_if_wait;
    i0 = log_q.size();
    apply_fetch(32'h100, -1, lat);
    checkOutput("fetch_latency", lat, 3);
    checkOutput("fetch_stall_cycles", bus.perf_if_wait - p_if, 3);
    checkOutput("fetch_m_fields", {log_q[i0].we, log_q[i0].be, log_q[i0].addr}, {1'b0, 4'hF, 32'h100});

    $display("[TB] simultaneous store and fetch, data first");
    @(negedge clk);
    p_if = bus.perf_if_wait; p_d = bus.perf_d_wait;
    i0 = log_q.size();
    fork
      apply_data(1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, lat_d);
      apply_fetch(32'h104, -1, lat);
    join
    checkOutput("store_first", {log_q[i0].we, log_q[i0].be, log_q[i0].addr}, {1'b1, 4'h3, 32'h2000});
    checkOutput("store_wdata", log_q[i0].wdata, 32'hDEADBEEF);
    checkOutput("fetch_second", {log_q[i0+1].we, log_q[i0+1].be, log_q[i0+1].addr}, {1'b0, 4'hF, 32'h104});
    checkOutput("fetch_after_dvalid", log_q[i0+1].req_cyc - last_dv_cyc, 1);
    checkOutput("store_latency", lat_d, 3);
    checkOutput("queued_fetch_latency", lat, 6);
    checkOutput("queued_stall_cycles", {bus.perf_if_wait - p_if, bus.perf_d_wait - p_d}, {32'd6, 32'd3});
    apply_data(1'b0, 32'h2000, '0, 4'hF, lat_d);

    $display("[TB] grant held off four cycles");
    @(negedge clk);
    set_delays(4, 4, 1, 1);
    p_if = bus.perf_if_wait;
    apply_fetch(32'h140, -1, lat);
    checkOutput("gnt_delay_latency", lat, 7);
    checkOutput("gnt_delay_stall_cycles", bus.perf_if_wait - p_if, 7);

    $display("[TB] flush while waiting for response");
    @(negedge clk);
    set_delays(0, 0, 4, 4);
    i0 = log_q.size();
    apply_fetch(32'h180, 3, lat);
    repeat (8) @(negedge clk);
    checkOutput("flushed_fetch_issued", log_q[i0].addr, 32'h180);
    set_delays(0, 0, 1, 1);
    apply_fetch(32'h200, -1, lat);
    checkOutput("post_flush_latency", lat, 3);

    $display("[TB] flush while request awaits grant");
    @(negedge clk);
    set_delays(2, 2, 1, 1);
    i0 = log_q.size();
    apply_fetch(32'h1C0, 1, lat);
    repeat (10) @(negedge clk);
    checkOutput("req_flush_issued_once", log_q.size() - i0, 1);
    checkOutput("req_flush_queue_empty", if_q.size(), 0);

    $display("[TB] randomized traffic");
    set_delays(0, 3, 1, 3);
    applyStimulus(60);
    repeat (10) @(negedge clk);
    checkOutput("if_q_drained", if_q.size(), 0);
    checkOutput("d_q_drained", d_q.size(), 0);

    $display("[TB] reset during WAIT");
    set_delays(0, 0, 6, 6);
    @(negedge clk);
    bus.if_addr = 32'h300;
    bus.if_req  = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_ctl", {bus.m_req, bus.m_we, bus.m_be, bus.m_addr}, 0);
    checkOutput("midrst_m_wdata", bus.m_wdata, 0);
    checkOutput("midrst_valids", {bus.if_valid, bus.d_valid}, 0);
    checkOutput("midrst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    checkOutput("midrst_perf", {bus.perf_if_wait, bus.perf_d_wait}, 0);
    checkOutput("midrst_if_stall", bus.if_stall, 1);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_perf", {bus.perf_if_wait, bus.perf_d_wait}, 0);
    set_delays(0, 0, 1, 1);
    apply_fetch(32'h200, -1, lat);
    checkOutput("post_rst_latency", lat, 3);
    repeat (4) @(negedge clk);
    checkOutput("final_if_q_empty", if_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch (IF) and data (MEM) stages of the pipelined core; both stages share one unified memory port. The arbiter serialises requests with data priority and keeps at most one memory transaction outstanding. It generates per-stage stall signals that combine with the load-use stall from the hazard logic. A fetch that is in flight when a redirect flush arrives is discarded.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  redirect flush (branch taken / JAL / JALR)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- d_req, d_we  in  1 each  data request, write enable; held stable until d_valid
- d_addr  in  ADDR_W;  d_wdata  in  DATA_W;  d_be  in  DATA_W/8
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  one-cycle completion pulse (loads and stores)
- d_stall  out  1  d_req & ~d_valid
- m_req, m_we  out  1  memory request, write enable
- m_addr  out  ADDR_W;  m_wdata  out  DATA_W;  m_be  out  DATA_W/8
- m_gnt  in  1  memory accepted the request this cycle
- m_rvalid  in  1  response; exactly one per accepted request, no earlier than the cycle after m_gnt
- m_rdata  in  DATA_W  response data (don't-care for writes)
- perf_if_wait, perf_d_wait  out  32 each  stall-cycle counters; wrap on overflow

## Operation
- States: IDLE, REQ (m_req high, waiting for m_gnt), WAIT (waiting for m_rvalid), DROP (flushed fetch, waiting for m_rvalid to discard it). An owner register records IF or D.
- IDLE: an eligible d_req wins over if_req. If if_flush is high, the fetch is not eligible that cycle. A requester is also not eligible in the cycle its own valid is high, so the old request is never reissued. On a win, m_addr, m_we, m_wdata and m_be are registered (for a fetch: m_we=0, m_be all ones) and the FSM moves to REQ.
- REQ: m_req and all m_* fields are held stable until m_gnt. On m_gnt, go to WAIT, or to DROP if a flush is pending for a fetch owner.
- WAIT: on m_rvalid, register the response data and pulse the owner's valid in the next cycle; go to IDLE.
- Flush: if_flush in REQ or WAIT with owner IF sets drop-pending. REQ still completes its handshake; the FSM then enters DROP. In WAIT the FSM moves directly to DROP.
- DROP: on m_rvalid, discard the data, assert no if_valid, go to IDLE.
- Flush has no effect when the owner is D. Data accesses are never cancelled.
- if_valid is not gated by if_flush in the same cycle; the IF/ID flush discards it.
- No starvation: the one-cycle data ineligibility after d_valid gives a waiting fetch the slot.
- perf_if_wait increments on every cycle if_stall is high; perf_d_wait on every cycle d_stall is high.

## Timing
- Reset: state IDLE; m_req, m_we, m_addr, m_wdata, m_be = 0; if_valid, d_valid = 0; if_rdata, d_rdata = 0; perf counters 0; drop-pending 0.
- Reset is honoured mid-transaction: state is abandoned and the bench must re-reset memory.
- Latency (gnt in the same cycle as m_req, rvalid one cycle later): request seen in cycle t → m_req at t+1 → m_rvalid at t+2 → valid at t+3. Minimum 3 cycles.
- Each extra gnt or rvalid wait cycle adds 1 cycle of latency.
- Throughput: one transaction per 3 cycles at best.
- if_stall and d_stall are combinational from the inputs and the registered valids. All other outputs are registered.

## Structure
- all_pkgs gains: typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_DROP}; typedef enum logic owner_t {OWN_IF, OWN_D}.
- No sub-module; the FSM, registers and counters are a single module.

## Test plan
- Single fetch, if_addr=0x100, m_gnt immediate, m_rdata=0x00500093 at t+2 → if_valid=1 at t+3 with if_rdata=0x00500093, m_we=0, m_be=0xF; if_stall high for cycles t..t+2.
- d_req and if_req rise together, store d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3 → data issued first with m_we=1, m_be=0x3; the fetch issues in the cycle after d_valid.
- m_gnt held low 4 cycles → m_req and m_addr stay stable; valid arrives 4 cycles later than the minimum; perf counter grows by exactly the stall-cycle count.
- if_flush in WAIT for a fetch → the following m_rvalid produces no if_valid. A new if_addr=0x200 issues from IDLE afterwards and returns correct data.
- if_flush in REQ while m_gnt is delayed 2 cycles → m_req is held until gnt, the response is dropped, and there is no spurious if_valid.
- rst_n pulled low in WAIT → all outputs return to reset values asynchronously; after release the FSM is in IDLE and the perf counters are 0.
